i2c_register_block: RTL and testbench
=====================================

Name: i2c_register_block

Overview:
APB3 slave register file that sits between the APB bus master and the I2C master core. It holds the prescaler, command and address/RW configuration registers, and exposes the core status register read-only. It forwards TX bytes into the transmit FIFO and pops RX bytes from the receive FIFO with one-cycle enable pulses.

Parameters:
DATA_W, 8, data width of the bus and of all registers
ADDR_W, 8, APB address width
PRESCALER_RST, 8'h00, reset value of the prescaler register

Ports:
pclk_i  in  1  clock; all logic rises on its posedge
preset_i  in  1  synchronous reset, active-high
psel_i  in  1  APB select
penable_i  in  1  APB enable (access phase)
pwrite_i  in  1  1 = write, 0 = read
paddr_i  in  ADDR_W  register address
pwdata_i  in  DATA_W  write data
prdata_o  out  DATA_W  read data
pready_o  out  1  transfer-complete indication
receive_i  in  DATA_W  head byte of the RX FIFO (show-ahead)
status_i  in  DATA_W  status byte driven by the I2C core
prescaler_o  out  DATA_W  prescaler register
cmd_o  out  DATA_W  command register
address_rw_o  out  DATA_W  slave address[7:1] and R/W bit[0]
transmit_o  out  DATA_W  transmit data register, feeds the TX FIFO
tx_fifo_write_enable_o  out  1  TX FIFO push pulse
rx_fifo_read_enable_o  out  1  RX FIFO pop pulse

Behaviour:
- Register map:
  - 0x00 prescaler: RW.
  - 0x01 cmd: RW.
  - 0x02 transmit: RW. A write pushes the TX FIFO; a read returns the last written value.
  - 0x03 receive: RO. A read pops the RX FIFO.
  - 0x04 address_rw: RW.
  - 0x05 status: RO, returns status_i.
  - Unmapped addresses: reads return 0, writes are ignored.
  - Writes to RO addresses are ignored.
- Access condition: acc = psel_i & penable_i.
- No wait states: pready_o = acc, combinational. Setup phase (psel_i=1, penable_i=0) causes no side effects.
- Write: on the posedge with acc & pwrite_i, the addressed register loads pwdata_i. The output ports are the registers themselves, so the new value appears the cycle after the access.
- Read data:
  - prdata_o is combinational from paddr_i while psel_i & ~pwrite_i.
  - prdata_o = 0 when psel_i=0 or pwrite_i=1.
  - Addr 0x03 returns receive_i directly; addr 0x05 returns status_i directly.
- TX FIFO push:
  - tx_fifo_write_enable_o is a registered one-cycle pulse, high during the cycle after a write access to 0x02.
  - transmit_o already holds the new byte in that cycle.
  - Back-to-back writes produce one pulse per access.
- RX FIFO pop:
  - rx_fifo_read_enable_o is a registered one-cycle pulse, high during the cycle after a read access to 0x03.
  - The byte is captured by the master during the access; the pop happens after.
- A repeated read of any address other than 0x03 has no side effects.
- Reset, applied on a posedge with preset_i=1, overrides any simultaneous access:
  - prescaler_o = PRESCALER_RST.
  - cmd_o, address_rw_o and transmit_o = 0.
  - Both FIFO enables = 0.
  - A transfer in progress is dropped: no write takes effect and no pulse is issued.
- pready_o and prdata_o are combinational, so they follow the bus even during reset.

Decomposition:
- Shared package i2c_pkg holds:
  - address constants ADDR_PRESCALER=0x00, ADDR_CMD=0x01, ADDR_TRANSMIT=0x02, ADDR_RECEIVE=0x03, ADDR_ADDRESS_RW=0x04, ADDR_STATUS=0x05;
  - the DATA_W and ADDR_W defaults;
  - cmd bit-position constants shared with the I2C core.
- No sub-module; the block is a single flat module.

Test Plan:
- Reset: hold preset_i=1 for 2 cycles -> prescaler_o=00, cmd_o=00, address_rw_o=00, transmit_o=00, both enables=0.
- Write 0xAB to 0x02, then 0xBA to 0x04 (setup then access) -> pready_o=1 in each access; transmit_o=AB with tx_fifo_write_enable_o high exactly one cycle; address_rw_o=BA with no TX pulse.
- Read 0x02 twice, then read 0x04 -> prdata_o=AB in both accesses and BA in the third; no FIFO pulses.
- Read 0x03 with receive_i=0x5C -> prdata_o=5C during the access; rx_fifo_read_enable_o high for exactly the following cycle.
- Read 0x05 with status_i=0x81, write 0x77 to 0x05 and to 0x07 -> read returns 81; the writes change no register; reading 0x07 returns 00.
- Write 0x12 to 0x00 with preset_i asserted on the access edge -> prescaler_o stays 00; no pulses.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master: register map, bus width defaults
// and command-register bit positions decoded by the I2C core.
package i2c_pkg;

   localparam int DEFAULT_DATA_W = 8;
   localparam int DEFAULT_ADDR_W = 8;

   localparam logic [7:0] ADDR_PRESCALER  = 8'h00;
   localparam logic [7:0] ADDR_CMD        = 8'h01;
   localparam logic [7:0] ADDR_TRANSMIT   = 8'h02;
   localparam logic [7:0] ADDR_RECEIVE    = 8'h03;
   localparam logic [7:0] ADDR_ADDRESS_RW = 8'h04;
   localparam logic [7:0] ADDR_STATUS     = 8'h05;

   // Bit positions inside the cmd register, as decoded by the I2C core
   localparam int CMD_START_BIT = 7;
   localparam int CMD_STOP_BIT  = 6;
   localparam int CMD_READ_BIT  = 5;
   localparam int CMD_WRITE_BIT = 4;
   localparam int CMD_NACK_BIT  = 3;
   localparam int CMD_IACK_BIT  = 0;

endpackage

// File: rtl/i2c_register_block.sv
// APB3 register file for the I2C master: config registers, TX push and RX pop strobes.
// Latency: reads are combinational in the access phase; register updates and FIFO pulses land one cycle after the access.
// Backpressure: none; pready_o is asserted on every access (zero wait states).
module i2c_register_block
   import i2c_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter logic [DATA_W-1:0] PRESCALER_RST = '0
) (
   input  logic              pclk_i,
   input  logic              preset_i,
   input  logic              psel_i,
   input  logic              penable_i,
   input  logic              pwrite_i,
   input  logic [ADDR_W-1:0] paddr_i,
   input  logic [DATA_W-1:0] pwdata_i,
   output logic [DATA_W-1:0] prdata_o,
   output logic              pready_o,
   input  logic [DATA_W-1:0] receive_i,
   input  logic [DATA_W-1:0] status_i,
   output logic [DATA_W-1:0] prescaler_o,
   output logic [DATA_W-1:0] cmd_o,
   output logic [DATA_W-1:0] address_rw_o,
   output logic [DATA_W-1:0] transmit_o,
   output logic              tx_fifo_write_enable_o,
   output logic              rx_fifo_read_enable_o
);

   logic acc;
   logic wr_acc;
   logic rd_acc;

   assign acc      = psel_i & penable_i;
   assign wr_acc   = acc & pwrite_i;
   assign rd_acc   = acc & ~pwrite_i;
   assign pready_o = acc;

   // Reset wins over a coinciding access, so a dropped transfer never pulses a FIFO
   always_ff @(posedge pclk_i) begin
      if (preset_i) begin
         prescaler_o            <= PRESCALER_RST;
         cmd_o                  <= '0;
         address_rw_o           <= '0;
         transmit_o             <= '0;
         tx_fifo_write_enable_o <= 1'b0;
         rx_fifo_read_enable_o  <= 1'b0;
      end else begin
         tx_fifo_write_enable_o <= wr_acc && (paddr_i == ADDR_W'(ADDR_TRANSMIT));
         rx_fifo_read_enable_o  <= rd_acc && (paddr_i == ADDR_W'(ADDR_RECEIVE));
         if (wr_acc) begin
            case (paddr_i)
               ADDR_W'(ADDR_PRESCALER):  prescaler_o  <= pwdata_i;
               ADDR_W'(ADDR_CMD):        cmd_o        <= pwdata_i;
               ADDR_W'(ADDR_TRANSMIT):   transmit_o   <= pwdata_i;
               ADDR_W'(ADDR_ADDRESS_RW): address_rw_o <= pwdata_i;
               default: ;
            endcase
         end
      end
   end

   // Read mux is valid from the setup phase onward so the master sees stable data
   always_comb begin
      prdata_o = '0;
      if (psel_i && !pwrite_i) begin
         case (paddr_i)
            ADDR_W'(ADDR_PRESCALER):  prdata_o = prescaler_o;
            ADDR_W'(ADDR_CMD):        prdata_o = cmd_o;
            ADDR_W'(ADDR_TRANSMIT):   prdata_o = transmit_o;
            ADDR_W'(ADDR_RECEIVE):    prdata_o = receive_i;
            ADDR_W'(ADDR_ADDRESS_RW): prdata_o = address_rw_o;
            ADDR_W'(ADDR_STATUS):     prdata_o = status_i;
            default:                  prdata_o = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_register_block.sv
// Directed bench for the I2C APB register block: register map, strobes and reset precedence.
module tb_i2c_register_block;

   logic       pclk_i = 1'b0;
   logic       preset_i;
   logic       psel_i;
   logic       penable_i;
   logic       pwrite_i;
   logic [7:0] paddr_i;
   logic [7:0] pwdata_i;
   logic [7:0] prdata_o;
   logic       pready_o;
   logic [7:0] receive_i;
   logic [7:0] status_i;
   logic [7:0] prescaler_o;
   logic [7:0] cmd_o;
   logic [7:0] address_rw_o;
   logic [7:0] transmit_o;
   logic       tx_fifo_write_enable_o;
   logic       rx_fifo_read_enable_o;

   int total = 0;
   int bad   = 0;

   i2c_register_block dut (
      .pclk_i                 (pclk_i),
      .preset_i               (preset_i),
      .psel_i                 (psel_i),
      .penable_i              (penable_i),
      .pwrite_i               (pwrite_i),
      .paddr_i                (paddr_i),
      .pwdata_i               (pwdata_i),
      .prdata_o               (prdata_o),
      .pready_o               (pready_o),
      .receive_i              (receive_i),
      .status_i               (status_i),
      .prescaler_o            (prescaler_o),
      .cmd_o                  (cmd_o),
      .address_rw_o           (address_rw_o),
      .transmit_o             (transmit_o),
      .tx_fifo_write_enable_o (tx_fifo_write_enable_o),
      .rx_fifo_read_enable_o  (rx_fifo_read_enable_o)
   );

   always #5 pclk_i = ~pclk_i;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled here
   task automatic step();
      @(posedge pclk_i);
      #1;
   endtask

   task automatic bus(input logic sel, input logic en, input logic wr,
                      input logic [7:0] addr, input logic [7:0] data);
      psel_i    = sel;
      penable_i = en;
      pwrite_i  = wr;
      paddr_i   = addr;
      pwdata_i  = data;
      #1;
   endtask

   initial begin
      preset_i  = 1'b1;
      receive_i = 8'h00;
      status_i  = 8'h00;
      bus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

      // Reset held for two cycles
      step();
      step();
      chk("rst_prescaler", prescaler_o, 8'h00);
      chk("rst_cmd", cmd_o, 8'h00);
      chk("rst_address_rw", address_rw_o, 8'h00);
      chk("rst_transmit", transmit_o, 8'h00);
      chk("rst_tx_we", {7'd0, tx_fifo_write_enable_o}, 8'h00);
      chk("rst_rx_re", {7'd0, rx_fifo_read_enable_o}, 8'h00);
      chk("idle_pready", {7'd0, pready_o}, 8'h00);
      preset_i = 1'b0;

      // Write 0xAB to transmit
      step();
      bus(1'b1, 1'b0, 1'b1, 8'h02, 8'hAB);
      chk("tx_setup_pready", {7'd0, pready_o}, 8'h00);
      step();
      chk("tx_setup_no_pulse", {7'd0, tx_fifo_write_enable_o}, 8'h00);
      chk("tx_setup_no_write", transmit_o, 8'h00);
      bus(1'b1, 1'b1, 1'b1, 8'h02, 8'hAB);
      chk("tx_access_pready", {7'd0, pready_o}, 8'h01);
      chk("tx_access_prdata_zero", prdata_o, 8'h00);
      step();
      bus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("tx_value", transmit_o, 8'hAB);
      chk("tx_pulse_hi", {7'd0, tx_fifo_write_enable_o}, 8'h01);
      step();
      chk("tx_pulse_lo", {7'd0, tx_fifo_write_enable_o}, 8'h00);

      // Write 0xBA to address_rw
      bus(1'b1, 1'b0, 1'b1, 8'h04, 8'hBA);
      step();
      bus(1'b1, 1'b1, 1'b1, 8'h04, 8'hBA);
      chk("arw_access_pready", {7'd0, pready_o}, 8'h01);
      step();
      bus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("arw_value", address_rw_o, 8'hBA);
      chk("arw_no_tx_pulse", {7'd0, tx_fifo_write_enable_o}, 8'h00);

      // Read transmit twice, then address_rw
      for (int i = 0; i < 3; i++) begin
         logic [7:0] a;
         logic [7:0] e;
         a = (i < 2) ? 8'h02 : 8'h04;
         e = (i < 2) ? 8'hAB : 8'hBA;
         step();
         bus(1'b1, 1'b0, 1'b0, a, 8'h00);
         chk($sformatf("rd%0d_setup_prdata", i), prdata_o, e);
         step();
         bus(1'b1, 1'b1, 1'b0, a, 8'h00);
         chk($sformatf("rd%0d_access_prdata", i), prdata_o, e);
         chk($sformatf("rd%0d_pready", i), {7'd0, pready_o}, 8'h01);
         step();
         bus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
         chk($sformatf("rd%0d_no_pulses", i),
             {6'd0, tx_fifo_write_enable_o, rx_fifo_read_enable_o}, 8'h00);
      end

      // Read receive: byte visible during access, pop pulse the cycle after
      receive_i = 8'h5C;
      step();
      bus(1'b1, 1'b0, 1'b0, 8'h03, 8'h00);
      step();
      chk("rx_setup_no_pulse", {7'd0, rx_fifo_read_enable_o}, 8'h00);
      bus(1'b1, 1'b1, 1'b0, 8'h03, 8'h00);
      chk("rx_access_prdata", prdata_o, 8'h5C);
      step();
      bus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("rx_pulse_hi", {7'd0, rx_fifo_read_enable_o}, 8'h01);
      step();
      chk("rx_pulse_lo", {7'd0, rx_fifo_read_enable_o}, 8'h00);

      // Status read, writes to RO and unmapped addresses
      status_i = 8'h81;
      bus(1'b1, 1'b0, 1'b0, 8'h05, 8'h00);
      step();
      bus(1'b1, 1'b1, 1'b0, 8'h05, 8'h00);
      chk("status_prdata", prdata_o, 8'h81);
      step();
      bus(1'b1, 1'b0, 1'b1, 8'h05, 8'h77);
      step();
      bus(1'b1, 1'b1, 1'b1, 8'h05, 8'h77);
      step();
      bus(1'b1, 1'b0, 1'b1, 8'h07, 8'h77);
      step();
      bus(1'b1, 1'b1, 1'b1, 8'h07, 8'h77);
      step();
      bus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("ro_wr_prescaler", prescaler_o, 8'h00);
      chk("ro_wr_cmd", cmd_o, 8'h00);
      chk("ro_wr_transmit", transmit_o, 8'hAB);
      chk("ro_wr_address_rw", address_rw_o, 8'hBA);
      chk("ro_wr_no_pulse", {7'd0, tx_fifo_write_enable_o}, 8'h00);
      bus(1'b1, 1'b0, 1'b0, 8'h07, 8'h00);
      step();
      bus(1'b1, 1'b1, 1'b0, 8'h07, 8'h00);
      chk("unmapped_prdata", prdata_o, 8'h00);

      // cmd write and readback
      step();
      bus(1'b1, 1'b0, 1'b1, 8'h01, 8'h3C);
      step();
      bus(1'b1, 1'b1, 1'b1, 8'h01, 8'h3C);
      step();
      bus(1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
      chk("cmd_value", cmd_o, 8'h3C);
      chk("cmd_prdata", prdata_o, 8'h3C);

      // Back-to-back transmit writes: one pulse per access
      step();
      bus(1'b1, 1'b1, 1'b1, 8'h02, 8'h11);
      step();
      bus(1'b1, 1'b0, 1'b1, 8'h02, 8'h22);
      chk("b2b_first_pulse", {7'd0, tx_fifo_write_enable_o}, 8'h01);
      chk("b2b_first_value", transmit_o, 8'h11);
      step();
      bus(1'b1, 1'b1, 1'b1, 8'h02, 8'h22);
      chk("b2b_gap", {7'd0, tx_fifo_write_enable_o}, 8'h00);
      step();
      bus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("b2b_second_pulse", {7'd0, tx_fifo_write_enable_o}, 8'h01);
      chk("b2b_second_value", transmit_o, 8'h22);

      // Reset coinciding with a prescaler write access
      step();
      bus(1'b1, 1'b0, 1'b1, 8'h00, 8'h12);
      step();
      preset_i = 1'b1;
      bus(1'b1, 1'b1, 1'b1, 8'h00, 8'h12);
      chk("rst_acc_pready", {7'd0, pready_o}, 8'h01);
      step();
      preset_i = 1'b0;
      bus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("rst_acc_prescaler", prescaler_o, 8'h00);
      chk("rst_acc_cmd", cmd_o, 8'h00);
      chk("rst_acc_transmit", transmit_o, 8'h00);
      chk("rst_acc_no_pulses",
          {6'd0, tx_fifo_write_enable_o, rx_fifo_read_enable_o}, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
